// File: rtl/bsram_stream_reader_if.sv
// Bundle of the command, BSRAM port-B and output-stream signals of the BSRAM stream reader.
// The master modport is the reader's view. The slave modport is the view of the surrounding logic (BSRAM, consumer, commander).
interface bsram_stream_reader_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 14
);
   logic              cmd_start;
   logic [ADDR_W-1:0] cmd_base;
   logic [LEN_W-1:0]  cmd_len;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] adb;
   logic              ceb;
   logic              oce;
   logic [DATA_W-1:0] dout;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;

   modport master (
      input  cmd_start, cmd_base, cmd_len, dout, m_ready,
      output busy, done, adb, ceb, oce, m_valid, m_data
   );

   modport slave (
      output cmd_start, cmd_base, cmd_len, dout, m_ready,
      input  busy, done, adb, ceb, oce, m_valid, m_data
   );
endinterface

// File: rtl/bsram_stream_reader.sv
// Sequential read master for BSRAM port B: turns a (base, length) command into reads.
// It hides the fixed read latency and delivers the bytes through a credit-guarded skid FIFO as a valid/ready stream.
module bsram_stream_reader #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 14,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   bsram_stream_reader_if.master bus_io
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

   // The issue cycle is the first stage of the read pipeline.
   // Only the remaining RD_LAT-1 stages are registered, so RD_LAT must be at least 2.
   logic [RD_LAT-2:0] tag_q;

   logic              issue;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic              credit_ok;
   logic [CNT_W:0]    occupancy;

   assign push       = tag_q[RD_LAT-2];
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && bus_io.m_ready;

   // Count reads in flight as if they already occupy the FIFO. Then every issued read always has a free slot.
   assign occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
   assign credit_ok  = (occupancy < (CNT_W+1)'(FIFO_DEPTH));
   assign issue      = (state_q == S_ISSUE) && (remaining_q != '0) && credit_ok;

   assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      case (state_q)
         S_IDLE: begin
            if (bus_io.cmd_start) begin
               addr_d      = bus_io.cmd_base;
               remaining_d = bus_io.cmd_len;
               state_d     = (bus_io.cmd_len == '0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Look at next-state counts, so done follows the final handshake by one cycle.
            if (inflight_d == '0 && count_d == '0) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         inflight_q  <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         tag_q[0]    <= issue;
         for (int i = 1; i < RD_LAT - 1; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: a slot is only visible after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= bus_io.dout;
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

   assign bus_io.busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign bus_io.done    = (state_q == S_FINISH);
   assign bus_io.adb     = addr_q;
   assign bus_io.ceb     = issue;
   assign bus_io.oce     = bus_io.busy;
   assign bus_io.m_valid = !fifo_empty;
   assign bus_io.m_data  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
endmodule
